pll_reset_sequencer: RTL and testbench

Reset/clock-bring-up controller between the board PLL and the SoC core. It drives the PLL reset, waits for and qualifies PLL lock, and releases the core reset only after lock has been stable for a programmable window. It re-sequences the PLL on lock loss or on a software request, and after bounded lock timeouts it enters a sticky failure state. Runs on the free-running board clock. It replaces the direct `core reset = !pll_locked` coupling at chip top.

---
 rtl/pll_reset_sequencer.sv | 139 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and core-reset sequencer: holds the PLL in reset, qualifies lock
// over a stable window, releases the core, and re-sequences on lock loss or request.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 1024,
  parameter int RETRY_MAX      = 3
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RETRY_LIM   = 4'(RETRY_MAX);
  localparam bit               RETRY_BOUND = (RETRY_MAX != 0);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [3:0]         r_retry;
  logic [3:0]         w_retry_nxt;
  logic [3:0]         w_retry_inc;
  logic               r_lock_meta_p0;
  logic               r_lock_s_p1;
  logic               r_pll_rst;
  logic               r_core_reset;
  logic               r_ready;
  logic               r_fail;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign w_retry_inc = sat_inc4(r_retry);

  // Lock synchronizer: pll_locked is asynchronous to sys_clock
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      r_lock_meta_p0 <= 1'b0;
      r_lock_s_p1    <= 1'b0;
    end else begin
      r_lock_meta_p0 <= pll_locked;
      r_lock_s_p1    <= r_lock_meta_p0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    unique case (r_state)
      S_PLL_RST: begin
        if (r_cnt == RST_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (r_lock_s_p1) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_retry_nxt = w_retry_inc;
          if (RETRY_BOUND && (w_retry_inc >= RETRY_LIM)) w_state_nxt = S_FAIL;
          else                                           w_state_nxt = S_PLL_RST;
        end
      end
      S_STABLE: begin
        if (!r_lock_s_p1)              w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == STABLE_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt;
        if (!r_lock_s_p1) w_state_nxt = S_PLL_RST;
      end
      S_FAIL: begin
        w_cnt_nxt = r_cnt;
      end
      default: begin
        w_state_nxt = S_PLL_RST;
      end
    endcase

    if (w_state_nxt != r_state) w_cnt_nxt = '0;

    // A software request overrides any same-cycle timeout or lock event
    if (soft_reset_req) begin
      w_state_nxt = S_PLL_RST;
      w_retry_nxt = 4'd0;
      w_cnt_nxt   = '0;
    end
  end

  // State, counter and outputs; outputs decode next-state so they move with it
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      r_state      <= S_PLL_RST;
      r_cnt        <= '0;
      r_retry      <= 4'd0;
      r_pll_rst    <= 1'b1;
      r_core_reset <= 1'b1;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_retry      <= w_retry_nxt;
      r_pll_rst    <= (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_FAIL);
      r_core_reset <= (w_state_nxt != S_RUN);
      r_ready      <= (w_state_nxt == S_RUN);
      r_fail       <= (w_state_nxt == S_FAIL);
    end
  end

  assign pll_rst     = r_pll_rst;
  assign core_reset  = r_core_reset;
  assign ready       = r_ready;
  assign fail        = r_fail;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expectations are queued by edge index
// and a negedge monitor pops and compares them against the registered outputs.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .LOCK_STABLE   (8),
    .RETRY_MAX     (2)
  ) dut (
    .sys_clock     (clk),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .soft_reset_req(soft_reset_req),
    .pll_rst       (pll_rst),
    .core_reset    (core_reset),
    .ready         (ready),
    .fail          (fail),
    .retry_count   (retry_count)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge
  int edge_idx = -1;
  always @(posedge clk) edge_idx <= edge_idx + 1;

  typedef struct {
    int         at;
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   base     = 0;

  function automatic logic [7:0] pk(bit pr, bit cr, bit rd, bit fl, int rc);
    return {pr, cr, rd, fl, 4'(rc)};
  endfunction

  // Monitor: outputs are compared half a cycle after the edge they belong to
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] got;
    got = {pll_rst, core_reset, ready, fail, retry_count};
    while (q.size() > 0 && q[0].at <= edge_idx) begin
      e = q.pop_front();
      n_checks++;
      if (e.at < edge_idx)
        $display("FAIL %s: check missed (edge %0d, now %0d)", e.name, e.at, edge_idx);
      else if (got !== e.exp)
        $display("FAIL %s @edge %0d: got {pll_rst,core_reset,ready,fail,retry}=%b required %b",
                 e.name, e.at, got, e.exp);
      else
        n_pass++;
    end
  end

  task automatic push_abs(input int at, input string name, input logic [7:0] v);
    exp_t e;
    e.at = at; e.name = name; e.exp = v;
    q.push_back(e);
  endtask

  task automatic push_rel(input int k, input string name, input logic [7:0] v);
    push_abs(base + k, name, v);
  endtask

  task automatic wait_rel(input int k);
    while (edge_idx < base + k) @(negedge clk);
  endtask

  // Reset for two edges; the next rising edge after return is edge 0 of the scenario
  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b0;
    push_abs(edge_idx + 2, name, pk(1, 1, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    base = edge_idx + 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations still pending, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int e;
    reset          = 1'b0;
    pll_locked     = 1'b1;
    soft_reset_req = 1'b0;

    // Nominal bring-up followed by lock loss in RUN
    do_reset("rst_nominal");
    push_rel(0,  "nom_e0",    pk(1, 1, 0, 0, 0));
    push_rel(2,  "nom_e2",    pk(1, 1, 0, 0, 0));
    push_rel(3,  "nom_e3",    pk(0, 1, 0, 0, 0));
    push_rel(11, "nom_e11",   pk(0, 1, 0, 0, 0));
    push_rel(12, "nom_run",   pk(0, 0, 1, 0, 0));
    push_rel(21, "loss_e21",  pk(0, 0, 1, 0, 0));
    push_rel(22, "loss_e22",  pk(1, 1, 0, 0, 0));
    push_rel(25, "loss_e25",  pk(1, 1, 0, 0, 0));
    push_rel(26, "loss_wait", pk(0, 1, 0, 0, 0));
    wait_rel(19);
    pll_locked = 1'b0;
    drain();

    // Three-cycle lock glitch during STABLE restarts qualification
    pll_locked = 1'b1;
    do_reset("rst_glitch");
    push_rel(9,  "gl_stable", pk(0, 1, 0, 0, 0));
    push_rel(10, "gl_wait",   pk(0, 1, 0, 0, 0));
    push_rel(12, "gl_e12",    pk(0, 1, 0, 0, 0));
    push_rel(20, "gl_e20",    pk(0, 1, 0, 0, 0));
    push_rel(21, "gl_run",    pk(0, 0, 1, 0, 0));
    wait_rel(7);
    pll_locked = 1'b0;
    wait_rel(10);
    pll_locked = 1'b1;
    drain();

    // Reset asserted mid-STABLE, then full restart
    do_reset("rst_mid");
    push_rel(9,  "mid_stable", pk(0, 1, 0, 0, 0));
    push_rel(10, "mid_reset",  pk(1, 1, 0, 0, 0));
    wait_rel(9);
    reset = 1'b0;
    wait_rel(10);
    reset = 1'b1;
    base = edge_idx + 1;
    push_rel(2,  "re_e2",  pk(1, 1, 0, 0, 0));
    push_rel(3,  "re_e3",  pk(0, 1, 0, 0, 0));
    push_rel(12, "re_run", pk(0, 0, 1, 0, 0));
    drain();

    // Lock never arrives: two timeouts end in FAIL, then a soft reset recovers
    pll_locked = 1'b0;
    do_reset("rst_timeout");
    push_rel(34,  "to_e34",    pk(0, 1, 0, 0, 0));
    push_rel(35,  "to_retry1", pk(1, 1, 0, 0, 1));
    push_rel(39,  "to_wait2",  pk(0, 1, 0, 0, 1));
    push_rel(70,  "to_e70",    pk(0, 1, 0, 0, 1));
    push_rel(71,  "to_fail",   pk(1, 1, 0, 1, 2));
    push_rel(171, "fail_hold1", pk(1, 1, 0, 1, 2));
    push_rel(271, "fail_hold2", pk(1, 1, 0, 1, 2));
    wait_rel(275);
    pll_locked = 1'b1;
    wait_rel(285);
    e = base + 287;
    push_abs(e - 1,  "fail_hold3", pk(1, 1, 0, 1, 2));
    push_abs(e,      "soft_e",     pk(1, 1, 0, 0, 0));
    push_abs(e + 4,  "soft_wait",  pk(0, 1, 0, 0, 0));
    push_abs(e + 12, "soft_e12",   pk(0, 1, 0, 0, 0));
    // Recovery mirrors the reset path but with PLL_RST entered at edge e itself
    push_abs(e + 13, "soft_run",   pk(0, 0, 1, 0, 0));
    wait_rel(286);
    soft_reset_req = 1'b1;
    wait_rel(287);
    soft_reset_req = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
